// File: rtl/last_n_arbiter_pkg.sv
// rtl/last_n_arbiter_pkg.sv - shared defaults and derived widths for the last-N arbiter
package last_n_arbiter_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NUM   = 4;
    localparam int DEF_NREQ  = 4;

    localparam int DEF_ID_W  = $clog2(DEF_NREQ);
    localparam int DEF_POS_W = $clog2(DEF_NUM);

    localparam logic [15:0] HIT_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/last_n_arbiter_if.sv
// rtl/last_n_arbiter_if.sv - request/response bundle between requesters and the arbiter
import last_n_arbiter_pkg::*;

interface last_n_arbiter_if #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NUM   = DEF_NUM,
    parameter int NREQ  = DEF_NREQ
) ();

    localparam int ID_W  = $clog2(NREQ);
    localparam int POS_W = $clog2(NUM);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic                  rsp_hit;
    logic [POS_W-1:0]      rsp_pos;

    modport master (
        output req_valid, req_data,
        input  req_ready, rsp_valid, rsp_id, rsp_hit, rsp_pos
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, rsp_valid, rsp_id, rsp_hit, rsp_pos
    );

endinterface

// File: rtl/last_n_arbiter_mru_list.sv
// rtl/last_n_arbiter_mru_list.sv - most-recent-unique list with combinational lookup
import last_n_arbiter_pkg::*;

module mru_list #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NUM   = DEF_NUM
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     flush_in,
    input  logic                     upd_in,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     hit_out,
    output logic [$clog2(NUM)-1:0]   pos_out,
    output logic [NUM*WIDTH-1:0]     out,
    output logic [NUM-1:0]           out_valid
);

    localparam int POS_W = $clog2(NUM);

    logic [WIDTH-1:0] r_entry [NUM];
    logic [NUM-1:0]   r_valid;

    // Lookup against valid entries only; scanning downward lets the lowest index win
    always_comb begin
        hit_out = 1'b0;
        pos_out = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_entry[i] == data_in)) begin
                hit_out = 1'b1;
                pos_out = POS_W'(i);
            end
        end
    end

    // Move-to-front on update: a hit only shifts the entries above its old slot
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            for (int i = 0; i < NUM; i++) begin
                r_entry[i] <= '0;
            end
            r_valid <= '0;
        end else if (upd_in) begin
            r_entry[0] <= data_in;
            for (int i = 1; i < NUM; i++) begin
                if (!hit_out || (i <= int'(pos_out))) begin
                    r_entry[i] <= r_entry[i-1];
                end
            end
            if (!hit_out) begin
                r_valid <= {r_valid[NUM-2:0], 1'b1};
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM; g++) begin : g_out
            assign out[g*WIDTH +: WIDTH] = r_entry[g];
        end
    endgenerate

    assign out_valid = r_valid;

endmodule

// File: rtl/last_n_arbiter.sv
// rtl/last_n_arbiter.sv - round-robin arbiter feeding a most-recent-unique list
import last_n_arbiter_pkg::*;

module last_n_arbiter #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NUM   = DEF_NUM,
    parameter int NREQ  = DEF_NREQ
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  flush_in,
    last_n_arbiter_if.slave       bus,
    output logic [NUM*WIDTH-1:0]  list_out,
    output logic [NUM-1:0]        list_valid,
    output logic [15:0]           hit_count
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int POS_W = $clog2(NUM);

    logic [ID_W-1:0]  r_rr_ptr;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic             r_rsp_hit;
    logic [POS_W-1:0] r_rsp_pos;
    logic [15:0]      r_hit_count;

    logic [NREQ-1:0]  w_grant;
    logic [ID_W-1:0]  w_gnt_id;
    logic [ID_W-1:0]  w_scan;
    logic             w_found;
    logic             w_accept;
    logic [WIDTH-1:0] w_data;
    logic             w_hit;
    logic [POS_W-1:0] w_pos;

    // Round-robin pick: first valid requester at or after rr_ptr; index wraps naturally
    always_comb begin
        w_grant  = '0;
        w_gnt_id = '0;
        w_scan   = '0;
        w_found  = 1'b0;
        if (!rst_in && !flush_in) begin
            for (int k = 0; k < NREQ; k++) begin
                w_scan = r_rr_ptr + ID_W'(k);
                if (!w_found && bus.req_valid[w_scan]) begin
                    w_found  = 1'b1;
                    w_gnt_id = w_scan;
                end
            end
            w_grant[w_gnt_id] = w_found;
        end
    end

    assign bus.req_ready = w_grant;
    assign w_accept      = |(bus.req_valid & w_grant);
    assign w_data        = bus.req_data[int'(w_gnt_id)*WIDTH +: WIDTH];

    mru_list #(
        .WIDTH (WIDTH),
        .NUM   (NUM)
    ) u_list (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .flush_in  (flush_in),
        .upd_in    (w_accept),
        .data_in   (w_data),
        .hit_out   (w_hit),
        .pos_out   (w_pos),
        .out       (list_out),
        .out_valid (list_valid)
    );

    // Response, pointer and hit counter; flush leaves pointer and counter alone
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rr_ptr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_pos   <= '0;
            r_hit_count <= '0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rr_ptr  <= w_gnt_id + ID_W'(1);
                r_rsp_id  <= w_gnt_id;
                r_rsp_hit <= w_hit;
                r_rsp_pos <= w_hit ? w_pos : '0;
                if (w_hit && (r_hit_count != HIT_COUNT_MAX)) begin
                    r_hit_count <= r_hit_count + 16'd1;
                end
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_hit   = r_rsp_hit;
    assign bus.rsp_pos   = r_rsp_pos;
    assign hit_count     = r_hit_count;

endmodule

// File: tb/tb_last_n_arbiter.sv
// tb/tb_last_n_arbiter.sv - directed self-checking bench for last_n_arbiter
module tb_last_n_arbiter;

    logic        clk_in;
    logic        rst_in;
    logic        flush_in;
    logic [31:0] list_out;
    logic [3:0]  list_valid;
    logic [15:0] hit_count;

    int errors = 0;
    int checks = 0;

    last_n_arbiter_if #(.WIDTH(8), .NUM(4), .NREQ(4)) bus ();

    last_n_arbiter dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .flush_in   (flush_in),
        .bus        (bus),
        .list_out   (list_out),
        .list_valid (list_valid),
        .hit_count  (hit_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int id, input logic [7:0] v);
        bus.req_valid[id]       = 1'b1;
        bus.req_data[id*8 +: 8] = v;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        bus.req_valid = '0;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        flush_in = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_data = '0;
        tick();
        tick();
        @(negedge clk_in);
        checks++; if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %h want %h", bus.req_ready, 4'h0); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (list_valid !== 4'h0) begin errors++; $display("FAIL reset_list_valid: got %h want 0", list_valid); end
        checks++; if (list_out !== 32'h0) begin errors++; $display("FAIL reset_list_out: got %h want 0", list_out); end
        checks++; if (hit_count !== 16'h0) begin errors++; $display("FAIL reset_hit_count: got %h want 0", hit_count); end
        tick();
        rst_in = 1'b0;
        bus.req_valid = '0;
    endtask

    task automatic test_single();
        set_req(0, 8'h11);
        @(negedge clk_in);
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", bus.req_ready); end
        tick();
        set_req(0, 8'h22);
        @(negedge clk_in);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== 1'b0 || bus.rsp_id !== 2'd0)
            begin errors++; $display("FAIL single_rsp1: got v=%b h=%b id=%0d want v=1 h=0 id=0", bus.rsp_valid, bus.rsp_hit, bus.rsp_id); end
        tick();
        set_req(0, 8'h11);
        @(negedge clk_in);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== 1'b0)
            begin errors++; $display("FAIL single_rsp2: got v=%b h=%b want v=1 h=0", bus.rsp_valid, bus.rsp_hit); end
        tick();
        bus.req_valid = '0;
        @(negedge clk_in);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== 1'b1 || bus.rsp_pos !== 2'd1)
            begin errors++; $display("FAIL single_rsp3: got v=%b h=%b pos=%0d want v=1 h=1 pos=1", bus.rsp_valid, bus.rsp_hit, bus.rsp_pos); end
        checks++; if (list_out[15:0] !== 16'h2211) begin errors++; $display("FAIL single_list: got %h want 2211", list_out[15:0]); end
        checks++; if (list_valid !== 4'b0011) begin errors++; $display("FAIL single_list_valid: got %b want 0011", list_valid); end
        checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL single_hit_count: got %0d want 1", hit_count); end
        tick();
        @(negedge clk_in);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_idle_rsp: got %b want 0", bus.rsp_valid); end
        checks++; if (hit_count !== 16'd1 || list_valid !== 4'b0011)
            begin errors++; $display("FAIL single_idle_hold: got cnt=%0d lv=%b want cnt=1 lv=0011", hit_count, list_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8'hA0 + 8'(i));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            checks++; if (bus.req_ready !== 4'(1 << (k % 4)))
                begin errors++; $display("FAIL rr_grant_%0d: got %b want %b", k, bus.req_ready, 4'(1 << (k % 4))); end
            if (k > 0) begin
                checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'((k - 1) % 4))
                    begin errors++; $display("FAIL rr_rsp_id_%0d: got v=%b id=%0d want v=1 id=%0d", k, bus.rsp_valid, bus.rsp_id, (k - 1) % 4); end
            end
            tick();
        end
        bus.req_valid = '0;
        @(negedge clk_in);
        checks++; if (bus.rsp_id !== 2'd0 || bus.rsp_hit !== 1'b1 || bus.rsp_pos !== 2'd3)
            begin errors++; $display("FAIL rr_wrap_hit: got id=%0d h=%b pos=%0d want id=0 h=1 pos=3", bus.rsp_id, bus.rsp_hit, bus.rsp_pos); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int v = 1; v <= 5; v++) begin
            set_req(0, 8'(v));
            tick();
        end
        set_req(0, 8'h02);
        @(negedge clk_in);
        checks++; if (bus.rsp_hit !== 1'b0) begin errors++; $display("FAIL fill_last_miss: got %b want 0", bus.rsp_hit); end
        checks++; if (list_out !== 32'h02030405) begin errors++; $display("FAIL fill_list: got %h want 02030405", list_out); end
        checks++; if (list_valid !== 4'hF) begin errors++; $display("FAIL fill_list_valid: got %h want f", list_valid); end
        tick();
        bus.req_valid = '0;
        @(negedge clk_in);
        checks++; if (bus.rsp_hit !== 1'b1 || bus.rsp_pos !== 2'd3)
            begin errors++; $display("FAIL fill_tail_hit: got h=%b pos=%0d want h=1 pos=3", bus.rsp_hit, bus.rsp_pos); end
        checks++; if (list_out !== 32'h03040502) begin errors++; $display("FAIL fill_reorder: got %h want 03040502", list_out); end
        checks++; if (list_valid !== 4'hF || hit_count !== 16'd1)
            begin errors++; $display("FAIL fill_after: got lv=%h cnt=%0d want lv=f cnt=1", list_valid, hit_count); end
    endtask

    task automatic test_flush();
        set_req(0, 8'h09);
        set_req(1, 8'h05);
        flush_in = 1'b1;
        @(negedge clk_in);
        checks++; if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL flush_ready: got %b want 0000", bus.req_ready); end
        tick();
        flush_in = 1'b0;
        @(negedge clk_in);
        checks++; if (list_valid !== 4'h0 || list_out !== 32'h0)
            begin errors++; $display("FAIL flush_list: got lv=%h out=%h want lv=0 out=0", list_valid, list_out); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_rsp: got %b want 0", bus.rsp_valid); end
        checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL flush_hit_count: got %0d want 1", hit_count); end
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL flush_ptr_kept: got %b want 0010", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        @(negedge clk_in);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== 1'b0 || bus.rsp_id !== 2'd1)
            begin errors++; $display("FAIL flush_next_miss: got v=%b h=%b id=%0d want v=1 h=0 id=1", bus.rsp_valid, bus.rsp_hit, bus.rsp_id); end
        checks++; if (list_valid !== 4'b0001 || list_out !== 32'h00000005)
            begin errors++; $display("FAIL flush_next_list: got lv=%b out=%h want lv=0001 out=00000005", list_valid, list_out); end
    endtask

    task automatic test_reset_mid();
        set_req(2, 8'h33);
        tick();
        rst_in = 1'b1;
        bus.req_valid = '0;
        @(negedge clk_in);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2)
            begin errors++; $display("FAIL rstmid_accept: got v=%b id=%0d want v=1 id=2", bus.rsp_valid, bus.rsp_id); end
        tick();
        @(negedge clk_in);
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_hit !== 1'b0 || bus.rsp_pos !== 2'd0)
            begin errors++; $display("FAIL rstmid_rsp: got v=%b id=%0d h=%b pos=%0d want all 0", bus.rsp_valid, bus.rsp_id, bus.rsp_hit, bus.rsp_pos); end
        checks++; if (list_out !== 32'h0 || list_valid !== 4'h0 || hit_count !== 16'h0)
            begin errors++; $display("FAIL rstmid_state: got out=%h lv=%h cnt=%0d want all 0", list_out, list_valid, hit_count); end
        tick();
        rst_in = 1'b0;
        bus.req_valid = 4'hF;
        @(negedge clk_in);
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr: got %b want 0001", bus.req_ready); end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        set_req(0, 8'h77);
        repeat (65535) @(posedge clk_in);
        @(negedge clk_in);
        checks++; if (hit_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h want fffe", hit_count); end
        repeat (4466) @(posedge clk_in);
        #1;
        bus.req_valid = '0;
        @(negedge clk_in);
        checks++; if (hit_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", hit_count); end
        checks++; if (bus.rsp_hit !== 1'b1 || bus.rsp_pos !== 2'd0 || list_valid !== 4'b0001)
            begin errors++; $display("FAIL sat_rsp: got h=%b pos=%0d lv=%b want h=1 pos=0 lv=0001", bus.rsp_hit, bus.rsp_pos, list_valid); end
    endtask

    initial begin
        rst_in = 1'b1;
        flush_in = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_fill();
        test_flush();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/last_n_arbiter.md
LAST_N_ARBITER -- requirements
Module: last_n_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of each requested value.
REQ-002 The block SHALL have parameter NUM, default 4, giving the depth of the most-recent-unique list (power of two, at least 2).
REQ-003 The block SHALL have parameter NREQ, default 4, giving the number of requesters (power of two, at least 2).

Ports:
REQ-004 The block SHALL have port clk_in, input, width 1: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_in, input, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have port flush_in, input, width 1: clears the list on the next edge.
REQ-007 The block SHALL have port req_valid, input, width NREQ: per-requester request strobe.
REQ-008 The block SHALL have port req_data, input, width NREQ x WIDTH: per-requester value.
REQ-009 The block SHALL have port req_ready, output, width NREQ: one-hot grant, combinational.
REQ-010 The block SHALL have port rsp_valid, output, width 1: response strobe, registered.
REQ-011 The block SHALL have port rsp_id, output, width log2(NREQ): index of the requester being answered.
REQ-012 The block SHALL have port rsp_hit, output, width 1: the value was already in the list.
REQ-013 The block SHALL have port rsp_pos, output, width log2(NUM): list position of the hit before the update; 0 on a miss.
REQ-014 The block SHALL have port list_out, output, width NUM x WIDTH: list contents; entry 0 is the most recent.
REQ-015 The block SHALL have port list_valid, output, width NUM: per-entry valid flag.
REQ-016 The block SHALL have port hit_count, output, width 16: saturating count of accepted hits.

Function
REQ-017 The block SHALL assert at most one req_ready bit per cycle, and only for a requester whose req_valid is high.
REQ-018 The block SHALL grant round-robin: the first requester with req_valid high, scanning from pointer rr_ptr upward and wrapping at NREQ-1 to 0.
REQ-019 The block SHALL treat a request as accepted in a cycle where req_valid[i] and req_ready[i] are both high; a requester holds valid and data stable until it is accepted.
REQ-020 The block SHALL set rr_ptr to (granted index + 1) mod NREQ on each accept, and leave rr_ptr unchanged when nothing is accepted.
REQ-021 On an accept that hits at valid position p, the block SHALL write entry 0 with the value, shift entries 0..p-1 down by one, leave entries above p unchanged, and leave list_valid unchanged.
REQ-022 On an accept that misses, the block SHALL shift all entries down by one, drop entry NUM-1, write entry 0 with the value, and update list_valid to (list_valid << 1) | 1.
REQ-023 The block SHALL ignore invalid entries when matching.
REQ-024 The block SHALL drive rsp_valid, rsp_id, rsp_hit and rsp_pos on the edge after the accept (latency 1), with rsp_valid high for exactly one cycle per accept.
REQ-025 Back-to-back accepts SHALL see the list as updated by the previous accept, with no bubble cycles.
REQ-026 While flush_in is high, the block SHALL hold all req_ready low; on the next edge list_valid clears to 0 and list_out to 0.
REQ-027 flush_in SHALL NOT reset rr_ptr or hit_count.
REQ-028 The block SHALL increment hit_count on each hit accept and hold it at 0xFFFF once it reaches that value.
REQ-029 When no requester is valid, the block SHALL keep list, pointer and counter unchanged and drive rsp_valid low on the next edge.

Reset
REQ-030 With rst_in high at an edge, the block SHALL clear list_out, list_valid, rr_ptr, hit_count, rsp_valid, rsp_id, rsp_hit and rsp_pos to 0.
REQ-031 rst_in SHALL take priority over flush_in and any accept.
REQ-032 While rst_in is high, the block SHALL hold all req_ready low.
REQ-033 A response pending at reset SHALL be discarded.

Structure
REQ-034 A shared package SHALL hold the defaults for WIDTH, NUM and NREQ and the clog2-derived index widths.
REQ-035 The list SHALL be a sub-module mru_list with ports clk_in, rst_in, flush_in, upd_in, data_in, hit_out, pos_out, out and out_valid.
REQ-036 mru_list SHALL produce hit_out and pos_out combinationally.
REQ-037 Round-robin arbitration and response registers SHALL live in the top level.

Verification
REQ-038 Reset then single requester 0 sends 0x11, 0x22, 0x11 -> responses are miss, miss, then hit with pos 1; list = {0x11, 0x22}; hit_count = 1.
REQ-039 All four requesters valid continuously -> grants in order 0, 1, 2, 3, 0 on consecutive cycles, with rsp_id following one cycle later.
REQ-040 Five distinct values 0x01..0x05 -> list = {05, 04, 03, 02}, list_valid = 0xF; then 0x02 -> hit with pos 3, list = {02, 05, 04, 03}.
REQ-041 flush_in high for one cycle while requests are pending -> no grant that cycle, list_valid = 0 next cycle; the next 0x05 is a miss.
REQ-042 rst_in asserted in the cycle after an accept -> rsp_valid = 0, and all outputs are 0 on the following cycle.
REQ-043 hit_count preloaded near saturation by 70000 hit accepts -> hit_count holds at 0xFFFF.
